// File: rtl/per_req_fanout_tracker.sv
// Routes one request stream to one of two branches and tracks in-flight transactions
// so that a branch switch only happens after the old branch has drained. Optional macro: PE_FANOUT_ERR_CHECK_EN.
module per_req_fanout_tracker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH/8,
  parameter int ID_WIDTH        = 4,
  parameter int SEL_BIT         = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_req0_o,
  output logic                  data_req1_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [ID_WIDTH-1:0]   data_ID_o,
  input  logic                  data_gnt0_i,
  input  logic                  data_gnt1_i,
  input  logic                  data_r_valid0_i,
  input  logic                  data_r_valid1_i,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  err_o
);

  // state   | meaning
  // ST_IDLE | nothing in flight, either branch may be granted
  // ST_OUT0 | transactions in flight on branch 0
  // ST_OUT1 | transactions in flight on branch 1
  typedef enum logic [1:0] {ST_IDLE, ST_OUT0, ST_OUT1} state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_dest, w_dest_nxt;

  logic w_tgt, w_not_full, w_allow, w_acc, w_rsp_any, w_ret;

  assign data_add_o   = data_add_i;
  assign data_wen_o   = data_wen_i;
  assign data_wdata_o = data_wdata_i;
  assign data_be_o    = data_be_i;
  assign data_ID_o    = data_ID_i;

  assign w_tgt      = data_add_i[SEL_BIT];
  // Full blocks grant regardless of a same-cycle retire, keeping r_valid off the grant path.
  assign w_not_full = (r_cnt < CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_allow    = data_req_i & w_not_full & ((r_state == ST_IDLE) | (w_tgt == r_dest));

  assign data_req0_o = w_allow & ~w_tgt;
  assign data_req1_o = w_allow &  w_tgt;
  assign data_gnt_o  = w_allow & (w_tgt ? data_gnt1_i : data_gnt0_i);

  assign w_acc     = data_gnt_o;
  assign w_rsp_any = data_r_valid0_i | data_r_valid1_i;
  assign w_ret     = w_rsp_any & (r_cnt != '0);

  assign outstanding_o = r_cnt;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_dest_nxt  = r_dest;
    w_state_nxt = r_state;
    if (w_acc) begin
      w_dest_nxt = w_tgt;
    end
    if (w_acc && !w_ret) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end else if (!w_acc && w_ret) begin
      w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
    end
    case (r_state)
      ST_IDLE: begin
        if (w_acc) w_state_nxt = w_tgt ? ST_OUT1 : ST_OUT0;
      end
      ST_OUT0, ST_OUT1: begin
        if (!w_acc && w_ret && (r_cnt == CNT_WIDTH'(1))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dest  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dest  <= w_dest_nxt;
    end
  end

`ifdef PE_FANOUT_ERR_CHECK_EN
  logic r_err;
  logic w_err_ev;

  assign w_err_ev = (w_rsp_any & (r_cnt == '0))
                  | (data_r_valid0_i & data_r_valid1_i)
                  | ((r_cnt != '0) & (r_dest ? data_r_valid0_i : data_r_valid1_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_ev) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_per_req_fanout_tracker.sv
// Directed self-checking bench for per_req_fanout_tracker (default parameters, MAX_OUTSTANDING=4).
module tb_per_req_fanout_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [3:0]  data_ID_i;
  logic        data_gnt_o, data_req0_o, data_req1_o;
  logic [31:0] data_add_o;
  logic        data_wen_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [3:0]  data_ID_o;
  logic        data_gnt0_i, data_gnt1_i;
  logic        data_r_valid0_i, data_r_valid1_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  per_req_fanout_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_gnt_o(data_gnt_o), .data_req0_o(data_req0_o), .data_req1_o(data_req1_o),
    .data_add_o(data_add_o), .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o),
    .data_be_o(data_be_o), .data_ID_o(data_ID_o),
    .data_gnt0_i(data_gnt0_i), .data_gnt1_i(data_gnt1_i),
    .data_r_valid0_i(data_r_valid0_i), .data_r_valid1_i(data_r_valid1_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Advance one clock; inputs changed afterwards settle 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    data_req_i = 0; data_add_i = 0; data_wen_i = 1; data_wdata_i = 0;
    data_be_i = 0; data_ID_i = 0; data_gnt0_i = 1; data_gnt1_i = 1;
    data_r_valid0_i = 0; data_r_valid1_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", outstanding_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err_o); end
    n_tests++; if ({data_gnt_o, data_req0_o, data_req1_o} !== 3'b000) begin n_fail++; $display("FAIL reset_req got %03b exp 000", {data_gnt_o, data_req0_o, data_req1_o}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_read();
    data_req_i = 1; data_add_i = 32'h0000_0000; data_wen_i = 1;
    data_wdata_i = 32'hA5A5_1234; data_be_i = 4'hC; data_ID_i = 4'h9;
    #1;
    n_tests++; if ({data_req0_o, data_req1_o, data_gnt_o} !== 3'b101) begin n_fail++; $display("FAIL single_comb got %03b exp 101", {data_req0_o, data_req1_o, data_gnt_o}); end
    n_tests++; if ({data_wdata_o, data_be_o, data_ID_o, data_wen_o} !== {32'hA5A5_1234, 4'hC, 4'h9, 1'b1}) begin n_fail++; $display("FAIL single_payload got %h exp %h", {data_wdata_o, data_be_o, data_ID_o, data_wen_o}, {32'hA5A5_1234, 4'hC, 4'h9, 1'b1}); end
    tick();
    data_req_i = 0;
    n_tests++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL single_cnt1 got %0d exp 1", outstanding_o); end
    data_r_valid0_i = 1;
    tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL single_cnt0 got %0d exp 0", outstanding_o); end
    // Back in IDLE: a branch-1 request is granted straight away.
    data_req_i = 1; data_add_i = 32'h0000_0400;
    #1;
    n_tests++; if ({data_req0_o, data_req1_o, data_gnt_o} !== 3'b011) begin n_fail++; $display("FAIL single_idle_b1 got %03b exp 011", {data_req0_o, data_req1_o, data_gnt_o}); end
    tick();
    data_req_i = 0;
    data_r_valid1_i = 1;
    tick();
    data_r_valid1_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL single_b1_drain got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_full();
    data_req_i = 1; data_add_i = 32'h0; data_gnt0_i = 1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d exp 4", outstanding_o); end
    data_r_valid0_i = 1;
    #1;
    n_tests++; if ({data_req0_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL full_block got %02b exp 00", {data_req0_o, data_gnt_o}); end
    tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL full_retire got %0d exp 3", outstanding_o); end
    n_tests++; if ({data_req0_o, data_gnt_o} !== 2'b11) begin n_fail++; $display("FAIL full_resume got %02b exp 11", {data_req0_o, data_gnt_o}); end
    tick();
    data_req_i = 0;
    n_tests++; if (outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_refill got %0d exp 4", outstanding_o); end
    data_r_valid0_i = 1;
    for (int i = 0; i < 4; i++) tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", outstanding_o); end
    // Extra response at cnt==0 must not underflow.
    data_r_valid0_i = 1;
    tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL full_underflow got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_switch();
    data_req_i = 1; data_add_i = 32'h0;
    tick(); tick();
    n_tests++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL switch_cnt got %0d exp 2", outstanding_o); end
    data_add_i = 32'h0000_0400;
    #1;
    n_tests++; if ({data_req0_o, data_req1_o, data_gnt_o} !== 3'b000) begin n_fail++; $display("FAIL switch_block2 got %03b exp 000", {data_req0_o, data_req1_o, data_gnt_o}); end
    data_r_valid0_i = 1;
    tick();
    n_tests++; if ({data_req1_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL switch_block1 got %02b exp 00", {data_req1_o, data_gnt_o}); end
    tick();
    data_r_valid0_i = 0;
    n_tests++; if ({data_req0_o, data_req1_o, data_gnt_o} !== 3'b011) begin n_fail++; $display("FAIL switch_go got %03b exp 011", {data_req0_o, data_req1_o, data_gnt_o}); end
    tick();
    data_req_i = 0;
    n_tests++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL switch_cnt1 got %0d exp 1", outstanding_o); end
    data_r_valid1_i = 1;
    tick();
    data_r_valid1_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL switch_drain got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_simul();
    data_req_i = 1; data_add_i = 32'h0;
    tick(); tick();
    data_r_valid0_i = 1;
    tick();
    data_r_valid0_i = 0; data_req_i = 0;
    n_tests++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL simul_cnt got %0d exp 2", outstanding_o); end
    data_req_i = 1; data_add_i = 32'h0000_0400;
    #1;
    n_tests++; if ({data_req1_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL simul_dest got %02b exp 00", {data_req1_o, data_gnt_o}); end
    data_req_i = 0;
    data_r_valid0_i = 1;
    tick(); tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL simul_drain got %0d exp 0", outstanding_o); end
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef PE_FANOUT_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_pre got %0b exp 0", err_o); end
    data_r_valid1_i = 1;
    tick();
    data_r_valid1_i = 0;
    n_tests++; if (err_o !== exp_err) begin n_fail++; $display("FAIL err_set got %0b exp %0b", err_o, exp_err); end
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL err_cnt got %0d exp 0", outstanding_o); end
    tick(); tick();
    n_tests++; if (err_o !== exp_err) begin n_fail++; $display("FAIL err_hold got %0b exp %0b", err_o, exp_err); end
  endtask

  task automatic test_async_reset();
    data_req_i = 1; data_add_i = 32'h0;
    tick(); tick(); tick();
    data_req_i = 0;
    n_tests++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL arst_pre got %0d exp 3", outstanding_o); end
    #2;
    rst_n = 0;
    #1;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL arst_cnt got %0d exp 0", outstanding_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL arst_err got %0b exp 0", err_o); end
    rst_n = 1;
    tick();
    // Late response after reset is a cnt==0 response.
    data_r_valid0_i = 1;
    tick();
    data_r_valid0_i = 0;
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL arst_late got %0d exp 0", outstanding_o); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    do_reset();
    test_full();
    do_reset();
    test_switch();
    do_reset();
    test_simul();
    do_reset();
    test_err();
    do_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/per_req_fanout_tracker.md
# per_req_fanout_tracker

Request-side companion of the peripheral interconnect response fan-in. It routes one initiator request stream to one of two target branches, selected by an address bit. It counts outstanding transactions per destination and holds off any request that would switch branches while responses are still pending. As a result, the two response valids arriving at the downstream response fan-in are never asserted in the same cycle.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, write data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, 4, transaction ID width
- SEL_BIT, 10, address bit selecting the branch (0 → branch 0, 1 → branch 1)
- MAX_OUTSTANDING, 4, maximum in-flight transactions (≥1); counter width $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  initiator request
- data_add_i  in  ADDR_WIDTH  address
- data_wen_i  in  1  write enable, active-low (1 = read)
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  transaction ID
- data_gnt_o  out  1  grant to initiator
- data_req0_o / data_req1_o  out  1  request to branch 0 / 1
- data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o  out  as inputs  shared payload to both branches
- data_gnt0_i / data_gnt1_i  in  1  grant from branch 0 / 1
- data_r_valid0_i / data_r_valid1_i  in  1  response valid from branch 0 / 1 (monitored only)
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
- Target tgt = data_add_i[SEL_BIT]. The payload passes through combinationally and unmodified.
- States:
  - IDLE: cnt==0.
  - OUT0: cnt>0, dest=0.
  - OUT1: cnt>0, dest=1.
- allow = data_req_i & (cnt < MAX_OUTSTANDING) & (state==IDLE | tgt==dest).
- data_reqX_o = allow & (tgt==X).
- data_gnt_o = allow & data_gntX_i for X = tgt.
- Accept event acc = data_gnt_o. On acc, dest ← tgt.
- Retire event ret = data_r_valid0_i | data_r_valid1_i, counted only when cnt>0.
- cnt update: acc & !ret → +1; !acc & ret → −1; both → unchanged.
- Transitions:
  - IDLE → OUTt on acc.
  - OUTd → IDLE when cnt goes 1→0 with no acc in the same cycle.
  - OUTd → OUTd on any other change.
  - There is no direct OUT0↔OUT1 transition.
- Switching branches requires draining to IDLE. While draining, a blocked request holds data_req0_o/1_o low and data_gnt_o low. The initiator keeps its request and payload stable until granted.
- Full (cnt==MAX_OUTSTANDING): no new grant, even if a response retires in the same cycle. This keeps grant free of any combinational path from the r_valid inputs.
- A response with cnt==0 leaves cnt unchanged (saturates at 0); it does not underflow.

## Timing
- Request and grant paths: zero latency, purely combinational.
- cnt, dest, state and err_o are registered and update one edge after the event.
- A request blocked by a branch switch is granted no earlier than the cycle after the last response of the old branch. Minimum turnaround = 1 cycle after that response.
- Reset values, applied asynchronously on rst_n low:
  - cnt=0, state IDLE, dest=0, outstanding_o=0, err_o=0.
  - data_req0_o, data_req1_o and data_gnt_o follow the comb equations with cnt=0.
- Reset mid-operation drops all tracking. Responses arriving after reset are treated as cnt==0 responses.

## Configuration
- PE_FANOUT_ERR_CHECK_EN defined: err_o is set, and stays set until reset, on any of:
  - a response while cnt==0;
  - data_r_valid0_i & data_r_valid1_i in the same cycle;
  - a response from the branch ≠ dest while cnt>0.
- Not defined: err_o is tied to 0 and the check logic is absent. Counting behaviour is identical in both builds.

## Test plan
- Reset, then one read to 0x000 with data_gnt0_i=1 → data_req0_o=1, data_gnt_o=1, outstanding_o=1 next cycle; data_r_valid0_i pulse → outstanding_o=0, state IDLE.
- Four back-to-back grants to 0x000 (MAX_OUTSTANDING=4) → outstanding_o=4; fifth request → data_gnt_o=0 and data_req0_o=0, even in a cycle where data_r_valid0_i=1; grant resumes the cycle after.
- Two requests outstanding to branch 0, then a request to 0x400 → data_req1_o=0 until the second data_r_valid0_i; data_req1_o=1 and data_gnt_o=1 the following cycle.
- Simultaneous acc and data_r_valid0_i with cnt=2 → cnt stays 2, dest stays 0.
- With PE_FANOUT_ERR_CHECK_EN: data_r_valid1_i while idle → err_o=1 next cycle and held; without the macro → err_o=0 and cnt stays 0.
- Assert rst_n=0 asynchronously with cnt=3 → outstanding_o=0 and err_o=0 immediately, before any clock edge.
